// File: rtl/alu_key_ctrl_pkg.sv
// Shared state codes, key bit positions and defaults for the operator-entry sequencer.
package alu_key_ctrl_pkg;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_CALC = 3'd3,
    S_SHOW = 3'd4
  } state_e;

  localparam int K_INC  = 0;
  localparam int K_NEXT = 1;
  localparam int K_DEC  = 2;
  localparam int K_CLR  = 3;

  localparam int TIMEOUT_DEFAULT = 1000;

endpackage

// File: rtl/alu_calc_timer.sv
// Cycle counter for the calculation wait; expire flags the last allowed cycle.
module alu_calc_timer #(
  parameter int TIMEOUT = 1000
) (
  input  logic mclk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = (count_q == 16'(TIMEOUT - 1));

endmodule

// File: rtl/alu_key_ctrl.sv
// Key-driven operand/opcode editor that launches the ALU and latches its result or a timeout.
module alu_key_ctrl
  import alu_key_ctrl_pkg::*;
#(
  parameter int KEY_WIDTH  = 4,
  parameter int DATA_WIDTH = 4,
  parameter int OP_WIDTH   = 3,
  parameter int OP_NUM     = 8,
  parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic                      mclk,
  input  logic                      rst_n,
  input  logic [KEY_WIDTH-1:0]      key_value,
  input  logic                      key_flag,
  output logic [DATA_WIDTH-1:0]     alu_a,
  output logic [DATA_WIDTH-1:0]     alu_b,
  output logic [OP_WIDTH-1:0]       alu_op,
  output logic                      alu_start,
  input  logic                      alu_done,
  input  logic [2*DATA_WIDTH-1:0]   alu_result,
  output logic [2*DATA_WIDTH-1:0]   disp_data,
  output logic [2:0]                disp_sel,
  output logic                      busy,
  output logic                      err
);

  localparam int RW = 2 * DATA_WIDTH;
  localparam logic [DATA_WIDTH-1:0] ONE_D  = DATA_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0]   ONE_O  = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0]   OP_MAX = OP_WIDTH'(OP_NUM - 1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [OP_WIDTH-1:0]   op_q, op_d;
  logic [RW-1:0]         res_q, res_d;
  logic                  err_q, err_d;
  logic                  start_q, start_d;
  logic                  timer_clr, timer_en, timer_expire;

  // A key event needs the flag and exactly one pressed (low) bit.
  logic key_ev, ev_inc, ev_next, ev_dec, ev_clr;
  assign key_ev  = key_flag && $onehot(~key_value);
  assign ev_inc  = key_ev && !key_value[K_INC];
  assign ev_next = key_ev && !key_value[K_NEXT];
  assign ev_dec  = key_ev && !key_value[K_DEC];
  assign ev_clr  = key_ev && !key_value[K_CLR];

  alu_calc_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .mclk   (mclk),
    .rst_n  (rst_n),
    .clr    (timer_clr),
    .en     (timer_en),
    .expire (timer_expire)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    res_d     = res_q;
    err_d     = err_q;
    start_d   = 1'b0;
    timer_clr = 1'b0;
    timer_en  = 1'b0;
    if (ev_clr) begin
      state_d   = S_A;
      a_d       = '0;
      b_d       = '0;
      op_d      = '0;
      res_d     = '0;
      err_d     = 1'b0;
      timer_clr = 1'b1;
    end else begin
      case (state_q)
        S_A: begin
          if (ev_inc)       a_d = a_q + ONE_D;
          else if (ev_dec)  a_d = a_q - ONE_D;
          else if (ev_next) state_d = S_B;
        end
        S_B: begin
          if (ev_inc)       b_d = b_q + ONE_D;
          else if (ev_dec)  b_d = b_q - ONE_D;
          else if (ev_next) state_d = S_OP;
        end
        S_OP: begin
          if (ev_inc) begin
            op_d = (op_q == OP_MAX) ? '0 : op_q + ONE_O;
          end else if (ev_dec) begin
            op_d = (op_q == '0) ? OP_MAX : op_q - ONE_O;
          end else if (ev_next) begin
            state_d   = S_CALC;
            timer_clr = 1'b1;
            start_d   = 1'b1;
          end
        end
        S_CALC: begin
          // Completion wins over a timeout landing in the same cycle.
          if (alu_done) begin
            res_d   = alu_result;
            err_d   = 1'b0;
            state_d = S_SHOW;
          end else if (timer_expire) begin
            res_d   = '0;
            err_d   = 1'b1;
            state_d = S_SHOW;
          end else begin
            timer_en = 1'b1;
          end
        end
        S_SHOW: begin
          if (ev_next) begin
            state_d = S_A;
            err_d   = 1'b0;
          end
        end
        default: state_d = S_A;
      endcase
    end
  end

  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      err_q   <= err_d;
      start_q <= start_d;
    end
  end

  always_comb begin
    disp_data = '0;
    case (state_q)
      S_A:     disp_data = RW'(a_q);
      S_B:     disp_data = RW'(b_q);
      S_OP:    disp_data = RW'(op_q);
      S_SHOW:  disp_data = res_q;
      default: disp_data = '0;
    endcase
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = op_q;
  assign alu_start = start_q;
  assign err       = err_q;
  assign disp_sel  = state_q;
  assign busy      = (state_q == S_CALC);

endmodule

// File: tb/tb_alu_key_ctrl.sv
// Scoreboard bench: a behavioural model pushes expected outputs per cycle, popped after each edge.
module tb_alu_key_ctrl;

  localparam int TMO  = 16;
  localparam int OPN  = 6;

  logic       mclk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key_value = 4'hF;
  logic       key_flag = 1'b0;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_op;
  logic       alu_start;
  logic       alu_done = 1'b0;
  logic [7:0] alu_result = 8'h00;
  logic [7:0] disp_data;
  logic [2:0] disp_sel;
  logic       busy, err;

  alu_key_ctrl #(
    .KEY_WIDTH(4), .DATA_WIDTH(4), .OP_WIDTH(3), .OP_NUM(OPN), .TIMEOUT(TMO)
  ) dut (
    .mclk(mclk), .rst_n(rst_n), .key_value(key_value), .key_flag(key_flag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
    .alu_done(alu_done), .alu_result(alu_result), .disp_data(disp_data),
    .disp_sel(disp_sel), .busy(busy), .err(err)
  );

  always #5 mclk = ~mclk;

  typedef struct {
    string      tag;
    logic [2:0] sel;
    logic [7:0] data;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic       start;
    logic       busy;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state
  int       m_state = 0;
  logic [3:0] m_a = 0, m_b = 0;
  int       m_op = 0;
  logic [7:0] m_res = 0;
  logic     m_err = 0, m_start = 0;
  int       m_timer = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_step(input logic [3:0] kv, input logic kf, input logic dn,
                            input logic [7:0] res, input logic rn);
    logic ev, inc, nxt, dec, clr;
    m_start = 1'b0;
    if (!rn) begin
      m_state = 0; m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_err = 0; m_timer = 0;
      return;
    end
    ev  = kf && ($countones(~kv) == 1);
    inc = ev && !kv[0];
    nxt = ev && !kv[1];
    dec = ev && !kv[2];
    clr = ev && !kv[3];
    if (clr) begin
      m_state = 0; m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_err = 0; m_timer = 0;
    end else begin
      case (m_state)
        0: if (inc) m_a = m_a + 4'd1; else if (dec) m_a = m_a - 4'd1; else if (nxt) m_state = 1;
        1: if (inc) m_b = m_b + 4'd1; else if (dec) m_b = m_b - 4'd1; else if (nxt) m_state = 2;
        2: if (inc) m_op = (m_op + 1) % OPN;
           else if (dec) m_op = (m_op + OPN - 1) % OPN;
           else if (nxt) begin m_state = 3; m_timer = 0; m_start = 1'b1; end
        3: if (dn) begin m_res = res; m_err = 0; m_state = 4; end
           else if (m_timer == TMO - 1) begin m_err = 1; m_res = 0; m_state = 4; end
           else m_timer++;
        4: if (nxt) begin m_state = 0; m_err = 0; end
        default: m_state = 0;
      endcase
    end
  endtask

  task automatic push_expected(input string tag);
    exp_t e;
    e.tag = tag; e.sel = 3'(m_state); e.a = m_a; e.b = m_b; e.op = 3'(m_op);
    e.start = m_start; e.busy = (m_state == 3); e.err = m_err;
    case (m_state)
      0: e.data = {4'h0, m_a};
      1: e.data = {4'h0, m_b};
      2: e.data = 8'(m_op);
      4: e.data = m_res;
      default: e.data = 8'h00;
    endcase
    exp_q.push_back(e);
  endtask

  task automatic pop_compare();
    exp_t e;
    e = exp_q.pop_front();
    $display("txn %-8s sel=%0d data=%02h a=%h b=%h op=%0d start=%b busy=%b err=%b",
             e.tag, disp_sel, disp_data, alu_a, alu_b, alu_op, alu_start, busy, err);
    check({e.tag, ".sel"},   32'(disp_sel),  32'(e.sel));
    check({e.tag, ".data"},  32'(disp_data), 32'(e.data));
    check({e.tag, ".a"},     32'(alu_a),     32'(e.a));
    check({e.tag, ".b"},     32'(alu_b),     32'(e.b));
    check({e.tag, ".op"},    32'(alu_op),    32'(e.op));
    check({e.tag, ".start"}, 32'(alu_start), 32'(e.start));
    check({e.tag, ".busy"},  32'(busy),      32'(e.busy));
    check({e.tag, ".err"},   32'(err),       32'(e.err));
  endtask

  // Called on a falling edge: drive inputs, predict, then compare after the next rising edge.
  task automatic cyc(input string tag, input logic [3:0] kv, input logic kf,
                     input logic dn = 1'b0, input logic [7:0] res = 8'h00, input logic rn = 1'b1);
    key_value = kv; key_flag = kf; alu_done = dn; alu_result = res; rst_n = rn;
    model_step(kv, kf, dn, res, rn);
    push_expected(tag);
    @(negedge mclk);
    pop_compare();
  endtask

  task automatic key(input string tag, input logic [3:0] kv, input int n = 1);
    for (int i = 0; i < n; i++) begin
      cyc(tag, kv, 1'b1);
      cyc("idle", 4'hF, 1'b0);
    end
  endtask

  initial begin
    @(negedge mclk);
    cyc("rst", 4'hF, 1'b0, 1'b0, 8'h00, 1'b0);
    cyc("rst", 4'hF, 1'b0, 1'b0, 8'h00, 1'b0);
    check("rst_sel", 32'(disp_sel), 32'd0);
    check("rst_a", 32'(alu_a), 32'd0);

    key("inc", 4'b1110, 3);
    check("inc3_a", 32'(alu_a), 32'd3);
    check("inc3_disp", 32'(disp_data), 32'h03);
    key("dec", 4'b1011, 4);
    check("dec4_a", 32'(alu_a), 32'hF);

    key("clr", 4'b0111);
    key("inc", 4'b1110, 5);
    key("next", 4'b1101);
    key("inc", 4'b1110, 3);
    key("next", 4'b1101);
    key("inc", 4'b1110, 2);
    cyc("go", 4'b1101, 1'b1);
    check("go_start", 32'(alu_start), 32'd1);
    check("go_busy", 32'(busy), 32'd1);
    check("go_ops", {alu_a, alu_b, 5'd0, alu_op}, {4'd5, 4'd3, 5'd0, 3'd2});
    cyc("calc", 4'hF, 1'b0);
    check("start_once", 32'(alu_start), 32'd0);
    cyc("done", 4'hF, 1'b0, 1'b1, 8'h0F);
    check("show_sel", 32'(disp_sel), 32'd4);
    check("show_data", 32'(disp_data), 32'h0F);

    key("next", 4'b1101, 4);
    for (int i = 0; i < TMO; i++) cyc("wait", 4'hF, 1'b0);
    check("tmo_err", 32'(err), 32'd1);
    check("tmo_sel", 32'(disp_sel), 32'd4);
    cyc("late", 4'hF, 1'b0, 1'b1, 8'h55);
    check("late_data", 32'(disp_data), 32'd0);
    key("next", 4'b1101);
    check("exit_err", 32'(err), 32'd0);

    key("multi", 4'b1100);
    key("rel", 4'b1111);
    cyc("noflag", 4'b1110, 1'b0);
    cyc("noflag", 4'hF, 1'b0);

    key("next", 4'b1101, 3);
    cyc("clrdn", 4'b0111, 1'b1, 1'b1, 8'hAA);
    check("clrdn_sel", 32'(disp_sel), 32'd0);
    check("clrdn_a", 32'(alu_a), 32'd0);

    key("next", 4'b1101, 2);
    key("inc", 4'b1110, 5);
    check("op5", 32'(alu_op), 32'd5);
    key("inc", 4'b1110);
    check("op_wrap", 32'(alu_op), 32'd0);
    key("dec", 4'b1011);
    check("op_back", 32'(alu_op), 32'd5);

    cyc("go", 4'b1101, 1'b1);
    // Reset glitch that is high again before the edge must not reset.
    key_value = 4'hF; key_flag = 1'b0; alu_done = 1'b0; rst_n = 1'b0;
    #2 rst_n = 1'b1;
    model_step(4'hF, 1'b0, 1'b0, 8'h00, 1'b1);
    push_expected("glitch");
    @(negedge mclk);
    pop_compare();
    check("glitch_busy", 32'(busy), 32'd1);
    cyc("rst", 4'hF, 1'b0, 1'b0, 8'h00, 1'b0);
    check("rst2_all", {disp_sel, alu_a, alu_b, alu_op, 1'b0, err, busy, alu_start}, 32'd0);
    cyc("idle", 4'hF, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
